// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state type and
// default frame parameters.
package imem_loader_pkg;

    localparam int unsigned    DEFAULT_DEPTH      = 64;
    localparam logic [7:0]     DEFAULT_START_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer. word/word_done are combinational so the
// loader can register the completed word on the same edge as the 4th byte.
module word_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word
);

    logic [23:0] shreg;
    logic [1:0]  cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (byte_valid) begin
            // Newest byte enters at the top; the oldest ends up in [7:0].
            shreg <= {byte_in, shreg[23:8]};
            cnt   <= cnt + 2'd1;
        end
    end

    always_comb begin
        word      = {byte_in, shreg};
        word_done = byte_valid && (cnt == 2'd3);
    end

endmodule

// File: rtl/imem_loader.sv
// Serial-frame instruction-memory loader: parses START/LEN/data/CHK frames,
// writes words into instruction memory and holds the core in reset until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter logic [7:0]  START_BYTE = DEFAULT_START_BYTE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        state;
    logic [7:0]    len;
    logic [IW-1:0] index;
    logic [7:0]    chk;

    logic          frame_start;
    logic          pack_valid;
    logic          word_done;
    logic [31:0]   word;

    always_comb begin
        frame_start = rx_valid && (rx_data == START_BYTE) &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
        pack_valid  = rx_valid && (state == ST_DATA);
    end

    word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (frame_start),
        .byte_valid (pack_valid),
        .byte_in    (rx_data),
        .word_done  (word_done),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
            len       <= '0;
            index     <= '0;
            chk       <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (frame_start) begin
                        state     <= ST_LEN;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        cpu_reset <= 1'b1;
                        index     <= '0;
                        chk       <= '0;
                    end
                end
                ST_LEN: begin
                    if (rx_valid) begin
                        if ((rx_data != 8'd0) && (32'(rx_data) <= DEPTH)) begin
                            len   <= rx_data;
                            state <= ST_DATA;
                        end else begin
                            state <= ST_ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        chk <= chk ^ rx_data;
                    end
                    if (word_done) begin
                        we    <= 1'b1;
                        waddr <= 32'({index, 2'b00});
                        wdata <= word;
                        // LEN <= DEPTH keeps the index inside 0..DEPTH-1.
                        if (32'(index) == (32'(len) - 32'd1)) begin
                            state <= ST_CHECK;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (rx_valid) begin
                        busy <= 1'b0;
                        if (rx_data == chk) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; write strobes are logged at
// the falling edge and checked against hand-computed frames.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    imem_loader #(.DEPTH(64), .START_BYTE(8'hA5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            log_addr.push_back(waddr);
            log_data.push_back(wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input int idx,
                             input logic [31:0] a, input logic [31:0] d);
        if (idx < log_addr.size()) begin
            chk({tag, "_addr"}, log_addr[idx], a);
            chk({tag, "_data"}, log_data[idx], d);
        end else begin
            chk({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_flags(input string tag, input logic b, input logic d,
                             input logic e, input logic cr);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
    endtask

    // Each call presents one byte for exactly one rising edge; calls back to back
    // give a contiguous byte stream.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(2);

        // Reset state
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_waddr", waddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        // Stray bytes in IDLE
        send(8'h00); send(8'hFF); send(8'h13);
        idle(2);
        chk_flags("stray", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stray_writes", 32'(log_addr.size()), 32'd0);

        // Good load; CHK arrives in the same cycle as the second write strobe
        send(8'hA5);
        idle(1);
        chk_flags("start", 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'h02);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        send(8'h90);
        idle(2);
        chk("good_writes", 32'(log_addr.size()), 32'd2);
        chk_write("good_w0", 0, 32'h0, 32'h0000_0013);
        chk_write("good_w1", 1, 32'h4, 32'h0010_0093);
        chk_flags("good", 1'b0, 1'b1, 1'b0, 1'b0);

        // Stray bytes in DONE leave state untouched
        clear_log();
        send(8'h00); send(8'hFF); send(8'h13);
        idle(2);
        chk_flags("stray_done", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stray_done_writes", 32'(log_addr.size()), 32'd0);

        // Reload from DONE
        send(8'hA5);
        idle(1);
        chk_flags("reload_start", 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'h01);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        send(8'h22);
        idle(2);
        chk("reload_writes", 32'(log_addr.size()), 32'd1);
        chk_write("reload_w0", 0, 32'h0, 32'hDEAD_BEEF);
        chk_flags("reload", 1'b0, 1'b1, 1'b0, 1'b0);

        // Bad length 0
        clear_log();
        send(8'hA5); send(8'h00);
        idle(1);
        chk_flags("len0", 1'b0, 1'b0, 1'b1, 1'b1);
        // Bad length 65
        send(8'hA5);
        idle(1);
        chk_flags("len65_start", 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'h41);
        idle(1);
        chk_flags("len65", 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        chk("badlen_writes", 32'(log_addr.size()), 32'd0);

        // Bad checksum: writes still happen and are kept
        send(8'hA5); send(8'h02);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        send(8'h91);
        idle(2);
        chk("badchk_writes", 32'(log_addr.size()), 32'd2);
        chk_write("badchk_w0", 0, 32'h0, 32'h0000_0013);
        chk_write("badchk_w1", 1, 32'h4, 32'h0010_0093);
        chk_flags("badchk", 1'b0, 1'b0, 1'b1, 1'b1);

        // Maximum length (64) is accepted
        clear_log();
        send(8'hA5); send(8'h40);
        idle(1);
        chk_flags("len64", 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame with a partial word pending
        @(negedge clk);
        reset_n = 1'b0;
        idle(1);
        @(negedge clk);
        reset_n = 1'b1;
        send(8'hA5); send(8'h01); send(8'h13); send(8'h00);
        @(negedge clk);
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        idle(1);
        chk("midrst_we", {31'd0, we}, 32'd0);
        chk_flags("midrst", 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        chk("midrst_writes", 32'(log_addr.size()), 32'd0);

        // Complete frame after reset must assemble from a clean packer
        send(8'hA5); send(8'h01);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'h08);
        idle(2);
        chk("post_rst_writes", 32'(log_addr.size()), 32'd1);
        chk_write("post_rst_w0", 0, 32'h0, 32'h1234_5678);
        chk_flags("post_rst", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
